// File: rtl/cmac_tx_pkt_buffer_if.sv
// AXI4-Stream bundle (data, keep, last, single-bit user) shared by the ingress and egress sides of the TX packet buffer.
interface cmac_tx_pkt_buffer_if #(
  parameter int DATA_W = 512
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tuser;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cmac_tx_pkt_buffer.sv
// Store-and-forward TX packet buffer: egress valid 2 cycles after a commit, then back-to-back until tlast; oversize packets
// (and, with CMAC_TX_PKT_ERR_DROP_EN, tuser-flagged ones) are dropped. Ingress stalls only while the RAM is full.
module cmac_tx_pkt_buffer #(
  parameter int DATA_W        = 512,
  parameter int DEPTH         = 256,
  parameter int MAX_PKT_BEATS = 128,
  parameter int CNT_W         = 16,
  localparam int KEEP_W       = DATA_W / 8,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  cmac_tx_pkt_buffer_if.slave  s_axis,
  cmac_tx_pkt_buffer_if.master m_axis,
  output logic [ADDR_W:0]      pkt_count,
  output logic [ADDR_W:0]      fifo_level,
  output logic [CNT_W-1:0]     drop_cnt
);
  localparam int WORD_W = DATA_W + KEEP_W + 1;
  localparam int BCNT_W = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, wr_commit, rd_ptr, fetch_ptr, used;
  logic [BCNT_W-1:0] beat_cnt;
  logic              init_done, s_ready, s_hs, pkt_err;
  logic              wr_en, commit, rollback;

  assign used          = wr_ptr - rd_ptr;
  assign s_ready       = init_done && ((state == DROP) || !used[ADDR_W]);
  assign s_hs          = s_axis.tvalid && s_ready;
  assign s_axis.tready = s_ready;

`ifdef CMAC_TX_PKT_ERR_DROP_EN
  logic err_seen;
  assign pkt_err = s_axis.tuser || err_seen;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                 err_seen <= 1'b0;
    else if (commit || rollback)  err_seen <= 1'b0;
    else if (wr_en && s_axis.tuser) err_seen <= 1'b1;
  end
`else
  logic unused_tuser;
  assign unused_tuser = s_axis.tuser;
  assign pkt_err      = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rollback  = 1'b0;
    case (state)
      IDLE, WRITE: begin
        wr_en = s_hs;
        if (s_hs) begin
          if (s_axis.tlast) begin
            state_nxt = IDLE;
            commit    = !pkt_err;
            rollback  = pkt_err;
          end else if (beat_cnt == BCNT_W'(MAX_PKT_BEATS - 1)) begin
            state_nxt = DROP;
            rollback  = 1'b1;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      DROP: begin
        if (s_hs && s_axis.tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_done <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
      beat_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      init_done <= 1'b1;
      // A rolled-back packet leaves the write pointer at the last commit point.
      if (rollback)   wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) wr_commit <= wr_ptr + 1'b1;
      if (commit || rollback) beat_cnt <= '0;
      else if (wr_en)         beat_cnt <= beat_cnt + 1'b1;
      if (rollback && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Egress: RAM read register followed by the output register, both fed only from committed beats.
  logic              rd_vld, out_load, rd_load, m_hs;
  logic [WORD_W-1:0] rd_q;
  logic              m_vld, m_last;
  logic [KEEP_W-1:0] m_keep;
  logic [DATA_W-1:0] m_data;

  assign m_hs     = m_vld && m_axis.tready;
  assign out_load = rd_vld && (!m_vld || m_axis.tready);
  assign rd_load  = (fetch_ptr != wr_commit) && (!rd_vld || out_load);

  always_ff @(posedge aclk) begin
    if (rd_load) rd_q <= mem[fetch_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      rd_vld    <= 1'b0;
      m_vld     <= 1'b0;
      m_last    <= 1'b0;
      m_keep    <= '0;
      m_data    <= '0;
      pkt_count <= '0;
    end else begin
      if (rd_load) fetch_ptr <= fetch_ptr + 1'b1;
      if (rd_load)       rd_vld <= 1'b1;
      else if (out_load) rd_vld <= 1'b0;
      if (out_load) begin
        m_vld                    <= 1'b1;
        {m_last, m_keep, m_data} <= rd_q;
      end else if (m_hs) begin
        m_vld <= 1'b0;
      end
      // Buffer space is released only at the egress handshake.
      if (m_hs) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, m_hs && m_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign fifo_level   = wr_commit - rd_ptr;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign m_axis.tuser  = 1'b0;
endmodule

// File: tb/tb_cmac_tx_pkt_buffer.sv
// Directed bench for cmac_tx_pkt_buffer: packet table plus hand sequences for latency, full buffer and mid-packet reset.
module tb_cmac_tx_pkt_buffer;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [8:0] pkt_count, fifo_level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  cmac_tx_pkt_buffer_if #(.DATA_W(DATA_W)) s_if ();
  cmac_tx_pkt_buffer_if #(.DATA_W(DATA_W)) m_if ();

  cmac_tx_pkt_buffer dut (
    .aclk(clk), .aresetn(aresetn), .s_axis(s_if), .m_axis(m_if),
    .pkt_count(pkt_count), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rx_beats = 0;
  int rdy_mode = 0;
  int exp_drop = 0;
  logic [577:0] exp_q[$];

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input int id, input int b);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = {id[15:0], b[15:0]} + 32'(w * 7919);
    return d;
  endfunction

  // m_axis_tready: 0 = always ready, 1 = pseudo-random, 2 = held low
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = 1'($urandom_range(0, 1));
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  logic in_pkt = 1'b0, gap_seen = 1'b0;
  always @(negedge clk) begin
    if (!aresetn) begin
      in_pkt   = 1'b0;
      gap_seen = 1'b0;
    end else if (m_if.tvalid && m_if.tready) begin
      rx_beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", {m_if.tlast, m_if.tkeep, m_if.tdata}, 640'd0);
      else chk("egress_beat", {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata}, exp_q.pop_front());
      if (m_if.tlast) begin
        chk("tvalid_gap_in_pkt", gap_seen, 1'b0);
        in_pkt   = 1'b0;
        gap_seen = 1'b0;
      end else begin
        in_pkt = 1'b1;
      end
    end else if (in_pkt && !m_if.tvalid) begin
      gap_seen = 1'b1;
    end
  end

  // Called and returns at posedge+1; stop_after>0 abandons the packet after that many beats.
  task automatic send_pkt(input int id, input int nb, input logic [63:0] lkeep,
                          input int err_beat, input int stop_after, input bit fwd);
    int w;
    for (int b = 0; b < nb; b++) begin
      if (stop_after > 0 && b == stop_after) break;
      s_if.tdata  = mk_data(id, b);
      s_if.tkeep  = (b == nb - 1) ? lkeep : '1;
      s_if.tlast  = (b == nb - 1);
      s_if.tuser  = (b + 1 == err_beat);
      s_if.tvalid = 1'b1;
      if (fwd) exp_q.push_back({1'b0, s_if.tlast, s_if.tkeep, s_if.tdata});
      w = 0;
      @(negedge clk);
      while (!s_if.tready && w < 2000) begin @(negedge clk); w++; end
      if (w >= 2000) begin
        chk("ingress_ready_timeout", 1'b0, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && w < 5000) begin @(posedge clk); #1; w++; end
    if (w >= 5000) chk("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    int          nbeats;
    logic [63:0] last_keep;
    int          err_beat;
    int          mode;
    bit          fwd;
    int          drop_after;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, n, base;
`ifdef CMAC_TX_PKT_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif
    // Five back-to-back 9-beat packets with random egress stalls, then drop and boundary cases.
    vecs[0]  = '{2, 9, 64'h3FF, 0, 1, 1'b1, 0};
    vecs[1]  = '{3, 9, 64'h3FF, 0, 1, 1'b1, 0};
    vecs[2]  = '{4, 9, 64'h3FF, 0, 1, 1'b1, 0};
    vecs[3]  = '{5, 9, 64'h3FF, 0, 1, 1'b1, 0};
    vecs[4]  = '{6, 9, 64'h3FF, 0, 1, 1'b1, 0};
    vecs[5]  = '{7, 129, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1'b0, 1};
    vecs[6]  = '{8, 2, 64'h0F, 0, 0, 1'b1, 1};
    vecs[7]  = '{9, 1, 64'h0, 0, 0, 1'b1, 1};
    vecs[8]  = '{10, 3, 64'hFF, 2, 0, !ERR_DROP, ERR_DROP ? 2 : 1};
    vecs[9]  = '{11, 4, 64'h1, 0, 0, 1'b1, ERR_DROP ? 2 : 1};
    vecs[10] = '{12, 128, 64'h7, 0, 1, 1'b1, ERR_DROP ? 2 : 1};
    vecs[11] = '{13, 1, 64'h3, 1, 0, !ERR_DROP, ERR_DROP ? 3 : 1};

    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    s_if.tdata = '0; s_if.tkeep = '0;

    // Reset state
    #22;
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, 640'd0);
    chk("rst_m_tlast_tkeep", {m_if.tlast, m_if.tkeep}, 640'd0);
    chk("rst_counters", {pkt_count, fifo_level, drop_cnt}, 640'd0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    chk("s_tready_after_release", s_if.tready, 1'b1);

    // Single 9-beat packet: first-beat latency and contiguity
    rdy_mode = 0;
    send_pkt(1, 9, 64'h3FF, 0, 0, 1'b1);
    chk("t1_pkt_count_commit", pkt_count, 9'd1);
    lat = 0;
    while (!m_if.tvalid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("t1_first_beat_latency", lat, 2);
    n = 0;
    while (m_if.tvalid && n < 20) begin n++; @(posedge clk); #1; end
    chk("t1_contiguous_beats", n, 9);
    chk("t1_pkt_count_after", pkt_count, 9'd0);

    // Table-driven packets
    for (int i = 0; i < 12; i++) begin
      rdy_mode = vecs[i].mode;
      send_pkt(vecs[i].id, vecs[i].nbeats, vecs[i].last_keep, vecs[i].err_beat, 0, vecs[i].fwd);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, 16'(vecs[i].drop_after));
    end
    rdy_mode = 0;
    wait_drain();
    chk("tbl_pkt_count_end", pkt_count, 9'd0);
    chk("tbl_fifo_level_end", fifo_level, 9'd0);
    exp_drop = vecs[11].drop_after;

    // Fill with two max-size packets while egress is stalled
    rdy_mode = 2;
    @(posedge clk); #1;
    base = rx_beats;
    send_pkt(20, 128, 64'hFFFF, 0, 0, 1'b1);
    send_pkt(21, 128, 64'h1FF, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("full_fifo_level", fifo_level, 9'd256);
    chk("full_pkt_count", pkt_count, 9'd2);
    chk("full_s_tready", s_if.tready, 1'b0);
    rdy_mode = 0;
    wait_drain();
    chk("full_drained_beats", rx_beats - base, 256);
    chk("full_s_tready_after", s_if.tready, 1'b1);
    chk("full_level_after", {pkt_count, fifo_level}, 640'd0);

    // Reset mid-packet with one complete packet held
    rdy_mode = 2;
    @(posedge clk); #1;
    send_pkt(40, 9, 64'h3FF, 0, 0, 1'b1);
    send_pkt(41, 9, 64'h3FF, 0, 4, 1'b0);
    chk("pre_rst_pkt_count", pkt_count, 9'd1);
    aresetn = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_s_tready", s_if.tready, 1'b0);
    chk("midrst_m_tvalid", m_if.tvalid, 1'b0);
    chk("midrst_m_tdata", m_if.tdata, 640'd0);
    chk("midrst_counters", {pkt_count, fifo_level, drop_cnt}, 640'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    chk("midrst_s_tready_release", s_if.tready, 1'b1);
    base = rx_beats;
    send_pkt(42, 5, 64'h3F, 0, 0, 1'b1);
    wait_drain();
    chk("post_rst_beats", rx_beats - base, 5);
    chk("post_rst_counters", {pkt_count, fifo_level}, 640'd0);
    chk("post_rst_drop_cnt", drop_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
